// File: rtl/mips_pkg.sv
// Shared MIPS definitions: mult/div unit enums plus the SPECIAL-opcode funct codes
// that the CPU decoder and the multiply/divide unit both rely on.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  // HI/LO instructions all live under the SPECIAL opcode, selected by funct.
  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// CPU-side request/response bundle of the multiply/divide unit.
interface mips_muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, op_a, op_b, mthi, mtlo,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, op_a, op_b, mthi, mtlo,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_datapath.sv
// One iteration of shift-add multiply (MUL_STEP_BITS multiplier bits) or restoring
// divide (one quotient bit); purely combinational, the caller holds the state.
module muldiv_datapath #(
  parameter int WIDTH         = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  logic [2*WIDTH-1:0] pp [MUL_STEP_BITS];
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               ge;

  genvar gi;
  generate
    for (gi = 0; gi < MUL_STEP_BITS; gi++) begin : g_pp
      assign pp[gi] = mplier[gi] ? (mcand << gi) : '0;
    end
  endgenerate

  always_comb begin
    mul_sum = acc;
    for (int i = 0; i < MUL_STEP_BITS; i++) begin
      mul_sum = mul_sum + pp[i];
    end
  end

  // Divide: acc[WIDTH-1:0] is the partial remainder, mplier shifts the dividend out
  // of its top while quotient bits enter at the bottom, mcand holds the divisor.
  assign trial = {acc[WIDTH-1:0], mplier[WIDTH-1]};
  assign ge    = trial >= {1'b0, mcand[WIDTH-1:0]};
  assign diff  = trial[WIDTH-1:0] - mcand[WIDTH-1:0];

  always_comb begin
    if (is_div) begin
      acc_next    = {{WIDTH{1'b0}}, (ge ? diff : trial[WIDTH-1:0])};
      mcand_next  = mcand;
      mplier_next = {mplier[WIDTH-2:0], ge};
    end else begin
      acc_next    = mul_sum;
      mcand_next  = mcand << MUL_STEP_BITS;
      mplier_next = mplier >> MUL_STEP_BITS;
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; start/busy/done handshake.
// Optional MIPS_MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MUL_STEP_BITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  mips_muldiv_unit_if.slave   bus
);

  localparam int N_MUL = WIDTH / MUL_STEP_BITS;
  localparam int N_DIV = WIDTH;
  localparam int CW    = $clog2(WIDTH);

  muldiv_state_t      state_reg, state_next;
  muldiv_op_t         op_reg;
  logic               neg_res_reg, neg_rem_reg, div0_reg, done_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg, mcand_reg, acc_step, mcand_step;
  logic [WIDTH-1:0]   mplier_reg, mplier_step;
  logic [WIDTH-1:0]   hi_reg, lo_reg, fix_hi, fix_lo;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_neg, b_neg, move, launch, early_out;

  assign move   = bus.mthi | bus.mtlo;
  assign launch = bus.start & ~move & (state_reg == IDLE);

  // op[0]=0 selects the signed variants (MULT, DIV).
  assign a_neg = ~bus.op[0] & bus.op_a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.op_b[WIDTH-1];
  assign a_mag = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag = b_neg ? -bus.op_b : bus.op_b;

  muldiv_datapath #(
    .WIDTH         (WIDTH),
    .MUL_STEP_BITS (MUL_STEP_BITS)
  ) u_datapath (
    .is_div      (state_reg == DIV),
    .acc         (acc_reg),
    .mcand       (mcand_reg),
    .mplier      (mplier_reg),
    .acc_next    (acc_step),
    .mcand_next  (mcand_step),
    .mplier_next (mplier_step)
  );

`ifdef MIPS_MULDIV_EARLY_OUT_EN
  assign early_out = (state_reg == MUL) && (mplier_step == '0);
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    if (move) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (bus.start) state_next = bus.op[1] ? DIV : MUL;
        MUL:  if (count_reg == CW'(N_MUL - 1) || early_out) state_next = FIX;
        DIV:  if (count_reg == CW'(N_DIV - 1)) state_next = FIX;
        FIX:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Division by zero leaves the dividend magnitude as remainder, so re-applying the
  // dividend sign reproduces the raw op_a; only the quotient needs forcing.
  always_comb begin
    fix_hi = hi_reg;
    fix_lo = lo_reg;
    case (op_reg)
      MD_MULT, MD_MULTU: {fix_hi, fix_lo} = neg_res_reg ? -acc_reg : acc_reg;
      default: begin
        fix_lo = div0_reg ? '1 : (neg_res_reg ? -mplier_reg : mplier_reg);
        fix_hi = neg_rem_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= MD_MULT;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
      done_reg    <= 1'b0;
      count_reg   <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else if (clk_enable) begin
      state_reg <= state_next;
      done_reg  <= (state_reg == FIX) && !move;
      if (launch) begin
        op_reg      <= bus.op;
        neg_res_reg <= a_neg ^ b_neg;
        neg_rem_reg <= a_neg;
        div0_reg    <= (bus.op_b == '0);
        count_reg   <= '0;
        acc_reg     <= '0;
        mcand_reg   <= {{WIDTH{1'b0}}, (bus.op[1] ? b_mag : a_mag)};
        mplier_reg  <= bus.op[1] ? a_mag : b_mag;
      end else if (state_reg == MUL || state_reg == DIV) begin
        count_reg  <= count_reg + 1'b1;
        acc_reg    <= acc_step;
        mcand_reg  <= mcand_step;
        mplier_reg <= mplier_step;
      end
      if (state_reg == FIX && !move) begin
        hi_reg <= fix_hi;
        lo_reg <= fix_lo;
      end
      if (bus.mthi) hi_reg <= bus.op_a;
      if (bus.mtlo) lo_reg <= bus.op_a;
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit owning the HI/LO architectural registers. It replaces the combinational mult/div path and the separate HI/LO register instances in the CPU datapath.
- Parametrised in operand width and multiply bits-per-cycle.
- Presents a start/busy/done handshake so the multi-cycle CPU control can stall on mfhi/mflo while an operation is in flight.
- Sits beside the ALU; the CPU drives it from decoded mult/multu/div/divu/mthi/mtlo instructions.

Parameters:
- WIDTH, 32: operand and HI/LO width; must be even, at least 4.
- MUL_STEP_BITS, 1: multiplier bits retired per iteration; must divide WIDTH (1, 2 or 4).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_enable  in  1  global clock enable; when low, all state is frozen
- start  in  1  launch operation; sampled only when clk_enable=1 and busy=0
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- op_a  in  WIDTH  rs value (multiplicand / dividend)
- op_b  in  WIDTH  rt value (multiplier / divisor)
- mthi  in  1  write op_a into HI
- mtlo  in  1  write op_a into LO
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; internal accumulators cleared.
- All synchronous updates require clk_enable=1. With clk_enable=0, every register holds its value, including done.
- FSM states:
  - IDLE -> MUL on start with op[1]=0.
  - IDLE -> DIV on start with op[1]=1.
  - MUL or DIV -> FIX after the last iteration.
  - FIX -> IDLE.
- Start edge: latch operand magnitudes (absolute values for signed ops), result signs and op. busy=1 from the next cycle.
- MUL: shift-add, MUL_STEP_BITS per cycle, N_MUL = WIDTH/MUL_STEP_BITS iterations. Unsigned 2*WIDTH product of the magnitudes.
- DIV: restoring, one quotient bit per cycle, N_DIV = WIDTH iterations.
- FIX: negate the result per latched signs, then write HI/LO. At this edge busy goes 0 and done goes 1 for exactly one cycle.
  - MULT/MULTU: {hi,lo} = product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
- Latency, start edge to HI/LO valid: N+1 edges. busy is high for N+1 cycles; for WIDTH=32, MUL_STEP_BITS=1 that is 33 cycles.
- Divide by zero: no trap. lo = all ones; hi = op_a (raw, unnegated). Same latency as a normal division.
- Signed overflow (DIV of most-negative value by -1): lo = most-negative value, hi = 0.
- start while busy: ignored; no effect on the running operation.
- mthi/mtlo:
  - Write HI/LO at the edge. If busy, they abort the running operation: state goes to IDLE, busy=0 next cycle, no done.
  - If start and mthi/mtlo are asserted together while idle, the move wins and start is ignored.
- done and a new start in the same cycle are legal. The new operation launches at that edge.
- Reset mid-operation: immediate abort; all outputs return to reset values.
- hi/lo are stable throughout an operation, holding their old values until FIX.

Optional Feature:
- Macro: MIPS_MULDIV_EARLY_OUT_EN.
- Defined: in MUL, if the remaining unshifted multiplier bits are all zero, jump directly to FIX. MULTU x*1 then completes in 2 cycles. Results are identical to the full-length path. Division is unaffected.
- Undefined: fixed latency of N+1 cycles for every operation.

Decomposition:
- Shared package mips_pkg:
  - muldiv_op_t enum: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - muldiv_state_t enum: IDLE, MUL, DIV, FIX.
  - Opcode and funct constants for mult/multu/div/divu/mfhi/mflo/mthi/mtlo, also used by the CPU decode.
- Sub-module muldiv_datapath: shift-add/restoring iteration step, parametrised by WIDTH and MUL_STEP_BITS. The FSM, sign handling and HI/LO registers stay in the top module.

Test Plan:
- MULT op_a=0xFFFFFFFD (-3), op_b=5 -> after 33 busy cycles: done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with MUL_STEP_BITS=4: same result, busy 9 cycles.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- Second start asserted at cycle 5 of a running DIVU 100/7 -> ignored; result lo=14, hi=2. mtlo op_a=0x1234 at cycle 10 of a MULT -> lo=0x1234, busy=0 next cycle, no done, hi unchanged.
- clk_enable held low for 10 cycles mid-MULT -> busy count extends by exactly 10; result unchanged.
- Reset asserted asynchronously mid-DIV (not at a clock edge) -> busy, done, hi, lo go to 0 immediately. Following MULTU 3x4 -> lo=12, hi=0.
